// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, with valid/ready handshaking and flush.
// Legal ops are pass, shift left/right, arithmetic shift right and rotate left/right. Ops 110/111 give zero data with err set.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [2:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_err,
    output logic                     out_zero
);

    localparam int SHW = $clog2(WIDTH);

    typedef struct packed {
        logic             valid;
        logic [2:0]       op;
        logic [SHW-1:0]   amt;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t stage_q [SHW];
    stage_t stage_d [SHW];

    logic advance;
    logic readyEn_q;
    logic err_q;
    logic zero_q;
    logic errLast;
    logic zeroLast;

    // One power-of-two step of the selected operation; unknown ops pass data through
    // and are zeroed at the last stage so every op sees the same latency.
    function automatic logic [WIDTH-1:0] shiftStep(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] d,
                                                   input int unsigned s);
        logic [WIDTH-1:0] r;
        case (op)
            3'b001:  r = d << s;
            3'b010:  r = d >> s;
            3'b011:  r = $signed(d) >>> s;
            3'b100:  r = (d << s) | (d >> (WIDTH - s));
            3'b101:  r = (d >> s) | (d << (WIDTH - s));
            default: r = d;
        endcase
        return r;
    endfunction

    assign advance  = out_ready | ~out_valid;
    // readyEn_q keeps the input closed during reset and for the first edge after release.
    assign in_ready = advance & ~flush & readyEn_q;

    always_comb begin
        stage_d[0].valid = in_valid & in_ready;
        stage_d[0].op    = in_op;
        stage_d[0].amt   = in_amt;
        stage_d[0].tag   = in_tag;
        stage_d[0].data  = in_amt[0] ? shiftStep(in_op, in_data, 1) : in_data;
        for (int k = 1; k < SHW; k++) begin
            stage_d[k] = stage_q[k-1];
            if (stage_q[k-1].amt[k]) begin
                stage_d[k].data = shiftStep(stage_q[k-1].op, stage_q[k-1].data, 1 << k);
            end
        end
        errLast = stage_d[SHW-1].op[2] & stage_d[SHW-1].op[1];
        if (errLast) begin
            stage_d[SHW-1].data = '0;
        end
        zeroLast = (stage_d[SHW-1].data == '0);
    end

    // Flush wins over advance: it only drops valid bits and leaves data in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SHW; k++) begin
                stage_q[k] <= '0;
            end
            err_q     <= 1'b0;
            zero_q    <= 1'b0;
            readyEn_q <= 1'b0;
        end else begin
            readyEn_q <= 1'b1;
            if (flush) begin
                for (int k = 0; k < SHW; k++) begin
                    stage_q[k].valid <= 1'b0;
                end
            end else if (advance) begin
                for (int k = 0; k < SHW; k++) begin
                    stage_q[k] <= stage_d[k];
                end
                err_q  <= errLast;
                zero_q <= zeroLast;
            end
        end
    end

    assign out_valid = stage_q[SHW-1].valid;
    assign out_data  = stage_q[SHW-1].data;
    assign out_tag   = stage_q[SHW-1].tag;
    assign out_err   = err_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=8): a scoreboard of arithmetic reference results
// is compared against every output handshake, plus directed literal results, backpressure, flush and reset.
module tb_pipelined_barrel_shifter;

    localparam int WIDTH = 8;
    localparam int TAG_W = 4;
    localparam int SHW   = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [SHW-1:0]   in_amt = '0;
    logic [2:0]       in_op = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic             out_zero;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             err;
        logic             zero;
        bit               hasLit;
        logic [WIDTH-1:0] lit;
        int               cyc;
        bit               lat;
    } entry_t;

    entry_t           sb[$];
    int               checkCount = 0;
    int               passCount  = 0;
    int               cycle      = 0;
    bit               latMode    = 1'b1;
    bit               bpMode     = 1'b0;
    bit               pendHasLit = 1'b0;
    logic [WIDTH-1:0] pendLit    = '0;

    pipelined_barrel_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_err(out_err), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference results straight from the operation definitions, rotates via a doubled word.
    function automatic logic [WIDTH-1:0] refModel(input logic [2:0] op, input logic [WIDTH-1:0] d,
                                                  input logic [SHW-1:0] amt);
        logic [2*WIDTH-1:0] dbl;
        logic [2*WIDTH-1:0] t;
        logic [WIDTH-1:0]   fill;
        dbl  = {d, d};
        fill = ~(8'hFF >> amt);
        case (op)
            3'd0: return d;
            3'd1: return d << amt;
            3'd2: return d >> amt;
            3'd3: return (d >> amt) | (d[WIDTH-1] ? fill : 8'h00);
            3'd4: begin t = dbl << amt; return t[2*WIDTH-1:WIDTH]; end
            3'd5: begin t = dbl >> amt; return t[WIDTH-1:0]; end
            default: return 8'h00;
        endcase
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        entry_t e;
        entry_t n;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = sb[0];
                    if (out_ready) begin
                        void'(sb.pop_front());
                        checkOutput("out_data", 32'(out_data), 32'(e.data));
                        checkOutput("out_tag", 32'(out_tag), 32'(e.tag));
                        checkOutput("out_err", 32'(out_err), 32'(e.err));
                        checkOutput("out_zero", 32'(out_zero), 32'(e.zero));
                        if (e.hasLit) checkOutput("literal_data", 32'(out_data), 32'(e.lit));
                        if (e.lat && latMode) checkOutput("latency", 32'(cycle - e.cyc), 32'd3);
                    end else begin
                        checkOutput("stall_data", 32'(out_data), 32'(e.data));
                        checkOutput("stall_tag", 32'(out_tag), 32'(e.tag));
                        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
                    end
                end
            end
            if (in_valid && in_ready) begin
                n.data   = refModel(in_op, in_data, in_amt);
                n.tag    = in_tag;
                n.err    = (in_op >= 3'd6);
                n.zero   = (n.data == 8'h00);
                n.hasLit = pendHasLit;
                n.lit    = pendLit;
                n.cyc    = cycle;
                n.lat    = latMode;
                sb.push_back(n);
            end
            if (flush) sb.delete();
        end
    end

    always @(posedge clk) begin
        if (bpMode) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the op.
    task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] d, input logic [SHW-1:0] amt,
                                 input logic [TAG_W-1:0] tag, input bit hasLit, input logic [WIDTH-1:0] lit);
        int n;
        in_valid   = 1'b1;
        in_op      = op;
        in_data    = d;
        in_amt     = amt;
        in_tag     = tag;
        pendHasLit = hasLit;
        pendLit    = lit;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        pendHasLit = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // Reset state and in_ready release timing.
        #12;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(out_data), 32'd0);
        checkOutput("reset_out_tag", 32'(out_tag), 32'd0);
        checkOutput("reset_out_err", 32'(out_err), 32'd0);
        checkOutput("reset_out_zero", 32'(out_zero), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("in_ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_edge", 32'(in_ready), 32'd1);

        // Directed ops with hand-computed results.
        applyStimulus(3'b100, 8'h81, 3'd1, 4'h1, 1'b1, 8'h03);
        applyStimulus(3'b101, 8'h01, 3'd1, 4'h2, 1'b1, 8'h80);
        applyStimulus(3'b011, 8'h80, 3'd3, 4'h3, 1'b1, 8'hF0);
        applyStimulus(3'b010, 8'h80, 3'd7, 4'h4, 1'b1, 8'h01);
        applyStimulus(3'b001, 8'h01, 3'd7, 4'h5, 1'b1, 8'h80);
        applyStimulus(3'b001, 8'h10, 3'd4, 4'h6, 1'b1, 8'h00);
        applyStimulus(3'b110, 8'h5A, 3'd2, 4'hA, 1'b1, 8'h00);
        applyStimulus(3'b111, 8'hFF, 3'd0, 4'hB, 1'b1, 8'h00);
        applyStimulus(3'b100, 8'hC3, 3'd0, 4'hC, 1'b1, 8'hC3);
        waitDrain();

        // Backpressure: three ops back to back, then stall for five cycles.
        latMode = 1'b0;
        applyStimulus(3'b000, 8'h11, 3'd0, 4'h1, 1'b0, 8'h00);
        applyStimulus(3'b001, 8'h22, 3'd1, 4'h2, 1'b0, 8'h00);
        applyStimulus(3'b010, 8'h33, 3'd2, 4'h3, 1'b0, 8'h00);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_held_tag", 32'(out_tag), 32'd1);
            checkOutput("bp_held_data", 32'(out_data), 32'h11);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checkOutput("bp_release_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_release_tag", 32'(out_tag), 32'(i));
        end
        @(posedge clk);
        #1;
        waitDrain();
        latMode = 1'b1;

        // Full-rate random stream.
        for (int i = 0; i < 64; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 3'($urandom), 4'($urandom), 1'b0, 8'h00);
        end
        waitDrain();

        // Flush: two ops in flight are dropped, an offer during flush is refused.
        @(posedge clk);
        #1;
        applyStimulus(3'b001, 8'h0F, 3'd1, 4'h7, 1'b0, 8'h00);
        applyStimulus(3'b010, 8'hF0, 3'd1, 4'h8, 1'b0, 8'h00);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = 3'b000;
        in_data  = 8'h99;
        in_tag   = 4'h9;
        @(negedge clk);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("flush_no_output", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(3'b100, 8'h81, 3'd4, 4'hD, 1'b1, 8'h18);
        waitDrain();

        // Reset with three ops in flight.
        @(posedge clk);
        #1;
        applyStimulus(3'b000, 8'hA1, 3'd0, 4'h1, 1'b0, 8'h00);
        applyStimulus(3'b000, 8'hA2, 3'd0, 4'h2, 1'b0, 8'h00);
        applyStimulus(3'b000, 8'hA3, 3'd0, 4'h3, 1'b0, 8'h00);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_reset_out_data", 32'(out_data), 32'd0);
        checkOutput("async_reset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("rerelease_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rerelease_in_ready_high", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("no_stale_after_reset", 32'(out_valid), 32'd0);
        end

        // Random stream under random backpressure.
        @(posedge clk);
        #1;
        latMode = 1'b0;
        bpMode  = 1'b1;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 3'($urandom), 4'($urandom), 1'b0, 8'h00);
        end
        bpMode = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitDrain();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
